// File: rtl/seg_red_unit.sv
// seg_red_unit
//   Pipelined segmented-reduction stage between the PE multiplier array and
//   the SpMM output buffer. Each beat carries N lane products and CSR split
//   flags. A log-depth segmented inclusive scan produces per-row partial
//   sums. An output stage adds the cross-beat carry to the first segment and
//   routes lane results to the outputs through out_idx.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high
//   in_valid   beat present on data/split/out_idx/in_clear
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_clear   drop the carry in front of this beat
//   data       N lanes of W bits, lane 0 in the low bits
//   split      split[i]=1 marks lane i as the last element of its segment
//   out_idx    N fields of LG_N bits; out_data[j] takes lane out_idx[j]
//   out_valid  out_data holds a result beat
//   out_ready  consumer takes the beat when out_valid && out_ready
//   out_data   N routed segment sums, lane 0 in the low bits
//   carry_out  current carry register
module seg_red_unit #(
  parameter int N        = 16,
  parameter int W        = 8,
  parameter int CARRY_EN = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_clear,
  input  logic [N*W-1:0]           data,
  input  logic [N-1:0]             split,
  input  logic [N*$clog2(N)-1:0]   out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*W-1:0]           out_data,
  output logic [W-1:0]             carry_out
);
  localparam int LG_N = $clog2(N);

  // Per-stage beat state. Stage 0 holds the raw beat and stages 1..LG_N
  // hold the scan after each doubling step.
  logic [N-1:0][W-1:0]    r_sum_p  [0:LG_N];
  logic [N-1:0]           r_pre_p  [0:LG_N];
  logic [N-1:0][LG_N-1:0] r_idx_p  [0:LG_N];
  logic [LG_N:0]          r_clr_p;
  logic [LG_N:0]          r_tail_p;
  logic [LG_N:0]          r_vld_p;

  logic                   r_out_valid;
  logic [N-1:0][W-1:0]    r_out_data;
  logic [W-1:0]           r_carry;

  logic                   w_advance;
  logic [N-1:0][W-1:0]    w_lanes;
  logic [N-1:0][LG_N-1:0] w_idx;
  logic [N-1:0][W-1:0]    w_sum_nxt [1:LG_N];
  logic [N-1:0]           w_pre_nxt [1:LG_N];
  logic [W-1:0]           w_carry_eff;
  logic [N-1:0][W-1:0]    w_res;
  logic [N-1:0][W-1:0]    w_route;
  logic [W-1:0]           w_carry_nxt;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance && !reset;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign carry_out = r_carry;
  assign w_lanes   = data;
  assign w_idx     = out_idx;

  // r_pre_p[k][i] is the OR of split over the window of lanes feeding lane i
  // after k steps, excluding lane i itself. For any lane at least d lanes
  // from lane 0, that window is exactly the set of lanes whose head flags the
  // classic scan would have merged. So "head seen" equals r_pre_p there, and
  // no separate head-flag vector is kept. After LG_N steps r_pre_p[i] is the
  // OR of split[0..i-1], which means lane i is not in the first segment.
  always_comb begin
    for (int k = 1; k <= LG_N; k++) begin
      w_sum_nxt[k] = r_sum_p[k-1];
      w_pre_nxt[k] = r_pre_p[k-1];
      for (int i = (1 << (k - 1)); i < N; i++) begin
        if (!r_pre_p[k-1][i]) begin
          w_sum_nxt[k][i] = r_sum_p[k-1][i] + r_sum_p[k-1][i - (1 << (k - 1))];
        end
        w_pre_nxt[k][i] = r_pre_p[k-1][i] | r_pre_p[k-1][i - (1 << (k - 1))];
      end
    end
  end

  // Output stage: the carry joins only the first segment of the beat.
  always_comb begin
    w_carry_eff = r_clr_p[LG_N] ? {W{1'b0}} : r_carry;
    w_res       = '0;
    w_route     = '0;
    for (int i = 0; i < N; i++) begin
      w_res[i] = r_sum_p[LG_N][i] + (r_pre_p[LG_N][i] ? {W{1'b0}} : w_carry_eff);
    end
    for (int j = 0; j < N; j++) begin
      w_route[j] = w_res[r_idx_p[LG_N][j]];
    end
    // An open tail segment (no split on the last lane) continues next beat.
    w_carry_nxt = (CARRY_EN != 0 && !r_tail_p[LG_N]) ? w_res[N-1] : {W{1'b0}};
  end

  // Data path registers are left unreset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (w_advance) begin
      // stage 0: capture the beat and seed the split prefix
      r_sum_p[0]  <= w_lanes;
      r_pre_p[0]  <= {split[N-2:0], 1'b0};
      r_idx_p[0]  <= w_idx;
      r_clr_p[0]  <= in_clear;
      r_tail_p[0] <= split[N-1];
      // stages 1..LG_N: one doubling scan step each
      for (int k = 1; k <= LG_N; k++) begin
        r_sum_p[k]  <= w_sum_nxt[k];
        r_pre_p[k]  <= w_pre_nxt[k];
        r_idx_p[k]  <= r_idx_p[k-1];
        r_clr_p[k]  <= r_clr_p[k-1];
        r_tail_p[k] <= r_tail_p[k-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_p     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_carry     <= '0;
    end else if (w_advance) begin
      r_vld_p     <= {r_vld_p[LG_N-1:0], in_valid};
      r_out_valid <= r_vld_p[LG_N];
      // output stage: register routed sums and update carry once per beat
      if (r_vld_p[LG_N]) begin
        r_out_data <= w_route;
        r_carry    <= w_carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_red_unit.sv
// tb_seg_red_unit
//   Directed bench for seg_red_unit at N=4, W=8, CARRY_EN=1. Each vector has
//   a hand-computed expected result. A single checking task counts and
//   reports every comparison.
module tb_seg_red_unit;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LG = 2;

  logic            clock     = 1'b0;
  logic            reset     = 1'b1;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic            in_clear  = 1'b0;
  logic [N*W-1:0]  data      = '0;
  logic [N-1:0]    split     = '0;
  logic [N*LG-1:0] out_idx   = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N*W-1:0]  out_data;
  logic [W-1:0]    carry_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  seg_red_unit #(.N(N), .W(W), .CARRY_EN(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_clear  (in_clear),
    .data      (data),
    .split     (split),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .carry_out (carry_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input int a, input int b, input int c, input int d);
    logic [7:0] la, lb, lc, ld;
    la = a[7:0]; lb = b[7:0]; lc = c[7:0]; ld = d[7:0];
    return {ld, lc, lb, la};
  endfunction

  function automatic logic [7:0] idx4(input int a, input int b, input int c, input int d);
    logic [1:0] ia, ib, ic, id;
    ia = a[1:0]; ib = b[1:0]; ic = c[1:0]; id = d[1:0];
    return {id, ic, ib, ia};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a beat and hold it until the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic [3:0] s, input logic [7:0] ix,
                      input logic clr);
    int t;
    data = d; split = s; out_idx = ix; in_clear = clr; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    check_val("send_accept", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid rises, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_val("out_valid_seen", {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic seen;
    logic [31:0] exp5 [3];

    tick();
    tick();
    check_val("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    check_val("rst_carry", {24'b0, carry_out}, 32'd0);
    reset = 1'b0;
    #1;
    check_val("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Single full-beat row, broadcast of lane 3
    send(lanes(1, 2, 3, 4), 4'b1000, idx4(3, 3, 3, 3), 1'b0);
    wait_out(lat);
    check_val("t1_latency", lat, 32'd3);
    check_val("t1_data", out_data, lanes(10, 10, 10, 10));
    check_val("t1_carry", {24'b0, carry_out}, 32'd0);
    tick();
    check_val("t1_drain", {31'b0, out_valid}, 32'd0);

    // Two segments
    send(lanes(1, 2, 3, 4), 4'b1010, idx4(1, 3, 1, 3), 1'b0);
    wait_out(lat);
    check_val("t2_data", out_data, lanes(3, 7, 3, 7));
    tick();

    // Carry from an open beat into the first segment of the next
    send(lanes(1, 1, 1, 1), 4'b0000, idx4(3, 3, 3, 3), 1'b1);
    wait_out(lat);
    check_val("t3a_data", out_data, lanes(4, 4, 4, 4));
    check_val("t3a_carry", {24'b0, carry_out}, 32'd4);
    tick();
    send(lanes(2, 2, 2, 2), 4'b1010, idx4(1, 3, 0, 2), 1'b0);
    wait_out(lat);
    check_val("t3b_data", out_data, lanes(8, 4, 6, 2));
    check_val("t3b_carry", {24'b0, carry_out}, 32'd0);
    tick();

    // Modulo-2^W wrap
    send(lanes(200, 200, 200, 200), 4'b1000, idx4(3, 3, 3, 3), 1'b0);
    wait_out(lat);
    check_val("t4_wrap", out_data, lanes(32, 32, 32, 32));
    tick();

    // Carry reaches only the first segment; the open tail becomes the new carry
    send(lanes(5, 0, 0, 0), 4'b0000, idx4(3, 3, 3, 3), 1'b1);
    wait_out(lat);
    check_val("t7a_data", out_data, lanes(5, 5, 5, 5));
    tick();
    send(lanes(1, 1, 1, 1), 4'b0010, idx4(0, 1, 2, 3), 1'b0);
    wait_out(lat);
    check_val("t7b_data", out_data, lanes(6, 7, 1, 2));
    check_val("t7b_carry", {24'b0, carry_out}, 32'd2);
    tick();
    // in_clear drops the nonzero carry
    send(lanes(1, 1, 1, 1), 4'b1000, idx4(0, 1, 2, 3), 1'b1);
    wait_out(lat);
    check_val("t7c_clear", out_data, lanes(1, 2, 3, 4));
    tick();

    // Back-to-back beats under a stalled consumer
    exp5[0] = lanes(1, 2, 3, 4);
    exp5[1] = lanes(5, 6, 7, 8);
    exp5[2] = lanes(9, 10, 11, 12);
    out_ready = 1'b0;
    send(lanes(1, 1, 1, 1), 4'b0000, idx4(0, 1, 2, 3), 1'b1);
    send(lanes(1, 1, 1, 1), 4'b0000, idx4(0, 1, 2, 3), 1'b0);
    send(lanes(1, 1, 1, 1), 4'b0000, idx4(0, 1, 2, 3), 1'b0);
    wait_out(lat);
    for (int c = 0; c < 5; c++) begin
      check_val("t5_stall_ready", {31'b0, in_ready}, 32'd0);
      check_val("t5_stall_data", out_data, exp5[0]);
      tick();
    end
    check_val("t5_stall_carry", {24'b0, carry_out}, 32'd4);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val("t5_order_valid", {31'b0, out_valid}, 32'd1);
      check_val("t5_order_data", out_data, exp5[k]);
      tick();
    end
    check_val("t5_empty", {31'b0, out_valid}, 32'd0);
    check_val("t5_carry", {24'b0, carry_out}, 32'd12);

    // Reset with beats in flight and carry = 9
    send(lanes(2, 2, 2, 3), 4'b0000, idx4(3, 3, 3, 3), 1'b1);
    wait_out(lat);
    check_val("t6_pre_data", out_data, lanes(9, 9, 9, 9));
    check_val("t6_pre_carry", {24'b0, carry_out}, 32'd9);
    tick();
    send(lanes(1, 1, 1, 1), 4'b0000, idx4(0, 1, 2, 3), 1'b0);
    send(lanes(1, 1, 1, 1), 4'b0000, idx4(0, 1, 2, 3), 1'b0);
    reset = 1'b1;
    #1;
    check_val("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check_val("t6_rst_carry", {24'b0, carry_out}, 32'd0);
    check_val("t6_rst_ready", {31'b0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check_val("t6_no_ghost", {31'b0, seen}, 32'd0);
    send(lanes(1, 2, 3, 4), 4'b0000, idx4(0, 1, 2, 3), 1'b0);
    wait_out(lat);
    check_val("t6_fresh_data", out_data, lanes(1, 3, 6, 10));
    check_val("t6_fresh_carry", {24'b0, carry_out}, 32'd10);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
